// File: rtl/muldiv_issue_pkg.sv
// Shared definitions for the mul/div issue queue and the mul/div execution unit:
// sizing, control-field bit positions, the divide classifier and the queue entry layout.
package muldiv_issue_pkg;

    localparam int CNTRL_SIZE = 7;
    localparam int NHART      = 1;
    localparam int LNHART     = 0;
    localparam int HART_W     = (LNHART > 0) ? LNHART : 1;
    localparam int NCOMMIT    = 32;
    localparam int LNCOMMIT   = 5;
    localparam int NQ         = 4;
    localparam int LNQ        = 2;

    // Control field bit positions, decoded identically by the unit
    localparam int CTL_BOPT   = 5;
    localparam int CTL_ADDW   = 4;
    localparam int CTL_INV    = 3;
    localparam int CTL_SGN_HI = 2;
    localparam int CTL_SGN_LO = 1;
    localparam int CTL_MUL    = 0;

    // One buffered op waiting for its operands
    typedef struct packed {
        logic                  valid;
        logic [CNTRL_SIZE-1:0] control;
        logic [LNCOMMIT-1:0]   rd;
        logic                  makes_rd;
        logic [HART_W-1:0]     hart;
        logic [LNCOMMIT-1:0]   rs1;
        logic [LNCOMMIT-1:0]   rs2;
        logic                  rs1_arch;
        logic                  rs2_arch;
    } issue_entry_t;

    // A divide is anything that is neither a bit-op nor a multiply; these use the iterative divider
    function automatic logic is_div(input logic [CNTRL_SIZE-1:0] ctl);
        return !ctl[CTL_BOPT] && !ctl[CTL_MUL];
    endfunction

endpackage

// File: rtl/muldiv_pick.sv
// Oldest-first priority picker: index 0 is the oldest queue slot and always wins.
module muldiv_pick
    import muldiv_issue_pkg::*;
#(
    parameter int N  = NQ,
    parameter int LN = LNQ
) (
    input  logic [N-1:0]  i_ready,
    output logic [N-1:0]  o_onehot,
    output logic [LN-1:0] o_index,
    output logic          o_any
);

    // Scan from youngest to oldest so the lowest ready index is the last one written
    always_comb begin
        o_onehot = '0;
        o_index  = '0;
        o_any    = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_ready[i]) begin
                o_onehot    = '0;
                o_onehot[i] = 1'b1;
                o_index     = LN'(i);
                o_any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/muldiv_issue.sv
// Issue queue in front of the mul/div unit: buffers renamed ops in a collapsing queue,
// wakes them on commit_ready, issues the oldest ready op per clock through registered
// outputs, and keeps divides away from the divider while it is occupied.
module muldiv_issue
    import muldiv_issue_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CNTRL_SIZE-1:0] in_control,
    input  logic [LNCOMMIT-1:0]   in_rd,
    input  logic                  in_makes_rd,
    input  logic [HART_W-1:0]     in_hart,
    input  logic [LNCOMMIT-1:0]   in_rs1,
    input  logic                  in_rs1_arch,
    input  logic [LNCOMMIT-1:0]   in_rs2,
    input  logic                  in_rs2_arch,
    input  logic [NCOMMIT-1:0]    commit_ready,
    input  logic [NCOMMIT-1:0]    commit_kill_0,
    input  logic                  divide_busy,
    output logic                  enable,
    output logic [CNTRL_SIZE-1:0] control,
    output logic [LNCOMMIT-1:0]   rd,
    output logic                  makes_rd,
    output logic [HART_W-1:0]     hart,
    output logic [LNCOMMIT-1:0]   rs1,
    output logic [LNCOMMIT-1:0]   rs2,
    output logic                  rs1_arch,
    output logic                  rs2_arch
);

    localparam logic [LNQ:0] NQ_CNT = (LNQ + 1)'(NQ);

    issue_entry_t r_q [NQ];
    logic [LNQ:0] r_count;
    logic         r_div_issued;

    logic [NQ-1:0]  w_ready;
    logic [NQ-1:0]  w_kill;
    logic [NQ-1:0]  w_onehot;
    logic [NQ-1:0]  w_remove;
    logic [LNQ-1:0] w_index;
    logic           w_any;
    logic           w_div_ok;
    logic           w_issue;
    logic           w_accept;
    issue_entry_t   w_pick;
    issue_entry_t   w_new;
    issue_entry_t   w_next [NQ];
    logic [LNQ:0]   w_pos;
    logic [LNQ:0]   w_next_count;

    // Admission is based on the registered occupancy only; a slot freed this clock opens next clock
    assign in_ready = (r_count < NQ_CNT);
    assign w_accept = in_valid && in_ready;

    // Per-slot wakeup, divide interlock and squash detection on the current commit vectors
    always_comb begin
        w_ready  = '0;
        w_kill   = '0;
        w_div_ok = !divide_busy && !r_div_issued;
        for (int i = 0; i < NQ; i++) begin
            w_kill[i]  = r_q[i].valid && commit_kill_0[r_q[i].rd];
            w_ready[i] = r_q[i].valid
                       && (r_q[i].rs1_arch || commit_ready[r_q[i].rs1])
                       && (r_q[i].rs2_arch || commit_ready[r_q[i].rs2])
                       && (!is_div(r_q[i].control) || w_div_ok);
        end
    end

    muldiv_pick #(
        .N  (NQ),
        .LN (LNQ)
    ) u_pick (
        .i_ready  (w_ready),
        .o_onehot (w_onehot),
        .o_index  (w_index),
        .o_any    (w_any)
    );

    // The pick is not retargeted when it is squashed; that clock simply issues nothing
    always_comb begin
        w_pick   = r_q[w_index];
        w_issue  = w_any && !w_kill[w_index];
        w_remove = w_kill | w_onehot;
    end

    // Incoming op as it will sit in the queue
    always_comb begin
        w_new          = '0;
        w_new.valid    = 1'b1;
        w_new.control  = in_control;
        w_new.rd       = in_rd;
        w_new.makes_rd = in_makes_rd;
        w_new.hart     = in_hart;
        w_new.rs1      = in_rs1;
        w_new.rs2      = in_rs2;
        w_new.rs1_arch = in_rs1_arch;
        w_new.rs2_arch = in_rs2_arch;
    end

    // Compaction: survivors slide down in age order, the new op lands right after them
    always_comb begin
        w_next = '{default: '0};
        w_pos  = '0;
        for (int i = 0; i < NQ; i++) begin
            if (r_q[i].valid && !w_remove[i]) begin
                w_next[w_pos[LNQ-1:0]] = r_q[i];
                w_pos = w_pos + (LNQ + 1)'(1);
            end
        end
        if (w_accept) begin
            w_next[w_pos[LNQ-1:0]] = w_new;
        end
        w_next_count = w_pos + {{LNQ{1'b0}}, w_accept};
    end

    // Queue storage, occupancy and the one-clock divide shadow
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q          <= '{default: '0};
            r_count      <= '0;
            r_div_issued <= 1'b0;
        end else begin
            r_q          <= w_next;
            r_count      <= w_next_count;
            r_div_issued <= w_issue && is_div(w_pick.control);
        end
    end

    // Registered issue port; fields hold their last value on idle clocks
    always_ff @(posedge clk) begin
        if (reset) begin
            enable   <= 1'b0;
            control  <= '0;
            rd       <= '0;
            makes_rd <= 1'b0;
            hart     <= '0;
            rs1      <= '0;
            rs2      <= '0;
            rs1_arch <= 1'b0;
            rs2_arch <= 1'b0;
        end else begin
            enable <= w_issue;
            if (w_issue) begin
                control  <= w_pick.control;
                rd       <= w_pick.rd;
                makes_rd <= w_pick.makes_rd;
                hart     <= w_pick.hart;
                rs1      <= w_pick.rs1;
                rs2      <= w_pick.rs2;
                rs1_arch <= w_pick.rs1_arch;
                rs2_arch <= w_pick.rs2_arch;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_issue.sv
// Bench for muldiv_issue: directed scenarios with hand-computed expectations, then
// randomized traffic, all checked every clock against a queue-based reference model.
module tb_muldiv_issue;

    localparam int NQ = 4;
    localparam logic [6:0] MUL = 7'b0000001;
    localparam logic [6:0] DIV = 7'b0000010;

    typedef struct {
        logic [6:0] control;
        logic [4:0] rd;
        logic       makesRd;
        logic [0:0] hart;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rs1Arch;
        logic       rs2Arch;
    } mop_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_control;
    logic [4:0]  in_rd;
    logic        in_makes_rd;
    logic [0:0]  in_hart;
    logic [4:0]  in_rs1;
    logic        in_rs1_arch;
    logic [4:0]  in_rs2;
    logic        in_rs2_arch;
    logic [31:0] commit_ready;
    logic [31:0] commit_kill_0;
    logic        divide_busy;
    logic        enable;
    logic [6:0]  control;
    logic [4:0]  rd;
    logic        makes_rd;
    logic [0:0]  hart;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_arch;
    logic        rs2_arch;

    int nCompares    = 0;
    int nMiscompares = 0;

    mop_t mq[$];
    mop_t nq[$];
    mop_t incoming;
    mop_t expOp;
    logic expEnable;
    logic expInReady;
    logic divLast;
    int   pick;

    always #5 clk = ~clk;

    muldiv_issue dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_control    (in_control),
        .in_rd         (in_rd),
        .in_makes_rd   (in_makes_rd),
        .in_hart       (in_hart),
        .in_rs1        (in_rs1),
        .in_rs1_arch   (in_rs1_arch),
        .in_rs2        (in_rs2),
        .in_rs2_arch   (in_rs2_arch),
        .commit_ready  (commit_ready),
        .commit_kill_0 (commit_kill_0),
        .divide_busy   (divide_busy),
        .enable        (enable),
        .control       (control),
        .rd            (rd),
        .makes_rd      (makes_rd),
        .hart          (hart),
        .rs1           (rs1),
        .rs2           (rs2),
        .rs1_arch      (rs1_arch),
        .rs2_arch      (rs2_arch)
    );

    function automatic mop_t zeroOp();
        mop_t z;
        z.control = '0; z.rd = '0; z.makesRd = 1'b0; z.hart = '0;
        z.rs1 = '0; z.rs2 = '0; z.rs1Arch = 1'b0; z.rs2Arch = 1'b0;
        return z;
    endfunction

    function automatic bit opIsDiv(input mop_t op);
        return (op.control[5] == 1'b0) && (op.control[0] == 1'b0);
    endfunction

    function automatic bit srcReady(input mop_t op, input logic [31:0] cr);
        return (op.rs1Arch || cr[op.rs1]) && (op.rs2Arch || cr[op.rs2]);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompares++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: an age-ordered list of pending ops, advanced once per rising edge
    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            expEnable = 1'b0;
            expOp     = zeroOp();
            divLast   = 1'b0;
        end else begin
            pick = -1;
            for (int i = 0; i < mq.size(); i++) begin
                if (pick < 0 && srcReady(mq[i], commit_ready)
                    && (!opIsDiv(mq[i]) || (!divide_busy && !divLast)))
                    pick = i;
            end
            expEnable = 1'b0;
            if (pick >= 0 && !commit_kill_0[mq[pick].rd]) begin
                expEnable = 1'b1;
                expOp     = mq[pick];
            end
            divLast = expEnable && opIsDiv(expOp);
            nq.delete();
            for (int i = 0; i < mq.size(); i++) begin
                if (i != pick && !commit_kill_0[mq[i].rd])
                    nq.push_back(mq[i]);
            end
            if (in_valid && mq.size() < NQ) begin
                incoming.control = in_control;  incoming.rd = in_rd;
                incoming.makesRd = in_makes_rd; incoming.hart = in_hart;
                incoming.rs1 = in_rs1;          incoming.rs2 = in_rs2;
                incoming.rs1Arch = in_rs1_arch; incoming.rs2Arch = in_rs2_arch;
                nq.push_back(incoming);
            end
            mq = nq;
        end
        expInReady = (mq.size() < NQ);
    end

    // Every clock, compare all DUT outputs with the model just after the edge
    always @(posedge clk) begin
        #1;
        checkOutput("enable",   32'(enable),   32'(expEnable));
        checkOutput("in_ready", 32'(in_ready), 32'(expInReady));
        checkOutput("control",  32'(control),  32'(expOp.control));
        checkOutput("rd",       32'(rd),       32'(expOp.rd));
        checkOutput("makes_rd", 32'(makes_rd), 32'(expOp.makesRd));
        checkOutput("hart",     32'(hart),     32'(expOp.hart));
        checkOutput("rs1",      32'(rs1),      32'(expOp.rs1));
        checkOutput("rs2",      32'(rs2),      32'(expOp.rs2));
        checkOutput("rs1_arch", 32'(rs1_arch), 32'(expOp.rs1Arch));
        checkOutput("rs2_arch", 32'(rs2_arch), 32'(expOp.rs2Arch));
    end

    task automatic applyStimulus(input logic v, input logic [6:0] ctl, input logic [4:0] rdv,
                                 input logic [4:0] s1, input logic a1,
                                 input logic [4:0] s2, input logic a2);
        in_valid    = v;
        in_control  = ctl;
        in_rd       = rdv;
        in_makes_rd = 1'b1;
        in_hart     = 1'b0;
        in_rs1      = s1;
        in_rs1_arch = a1;
        in_rs2      = s2;
        in_rs2_arch = a2;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        in_makes_rd   = 1'b0;
        commit_ready  = '0;
        commit_kill_0 = '0;
        divide_busy   = 1'b0;
        repeat (3) stepClock();
        checkOutput("reset enable",   32'(enable),   32'd0);
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset rd",       32'(rd),       32'd0);
        checkOutput("reset control",  32'(control),  32'd0);
        reset = 1'b0;

        // Scenario: single mul with arch sources, enable two clocks after alloc
        applyStimulus(1'b1, MUL, 5'd3, 5'd1, 1'b1, 5'd2, 1'b1);
        stepClock();
        in_valid = 1'b0;
        checkOutput("mul first clk enable", 32'(enable), 32'd0);
        stepClock();
        checkOutput("mul enable",   32'(enable),   32'd1);
        checkOutput("mul rd",       32'(rd),       32'd3);
        checkOutput("mul control",  32'(control),  32'(MUL));
        checkOutput("mul in_ready", 32'(in_ready), 32'd1);
        stepClock();
        checkOutput("mul idle", 32'(enable), 32'd0);

        // Scenario: back-to-back divides held off by the divide shadow then divide_busy
        applyStimulus(1'b1, DIV, 5'd4, 5'd1, 1'b1, 5'd2, 1'b1);
        stepClock();
        applyStimulus(1'b1, DIV, 5'd5, 5'd1, 1'b1, 5'd2, 1'b1);
        stepClock();
        in_valid = 1'b0;
        checkOutput("div4 enable", 32'(enable), 32'd1);
        checkOutput("div4 rd",     32'(rd),     32'd4);
        stepClock();
        checkOutput("div5 shadow hold", 32'(enable), 32'd0);
        divide_busy = 1'b1;
        stepClock();
        checkOutput("div5 busy hold a", 32'(enable), 32'd0);
        stepClock();
        checkOutput("div5 busy hold b", 32'(enable), 32'd0);
        divide_busy = 1'b0;
        stepClock();
        checkOutput("div5 enable", 32'(enable), 32'd1);
        checkOutput("div5 rd",     32'(rd),     32'd5);

        // Scenario: younger mul bypasses a divide blocked by divide_busy
        divide_busy = 1'b1;
        applyStimulus(1'b1, DIV, 5'd6, 5'd1, 1'b1, 5'd2, 1'b1);
        stepClock();
        applyStimulus(1'b1, MUL, 5'd7, 5'd1, 1'b1, 5'd2, 1'b1);
        stepClock();
        in_valid = 1'b0;
        checkOutput("bypass none yet", 32'(enable), 32'd0);
        stepClock();
        checkOutput("bypass mul7 enable", 32'(enable), 32'd1);
        checkOutput("bypass mul7 rd",     32'(rd),     32'd7);
        divide_busy = 1'b0;
        stepClock();
        checkOutput("bypass div6 enable", 32'(enable), 32'd1);
        checkOutput("bypass div6 rd",     32'(rd),     32'd6);
        stepClock();

        // Scenario: fill the queue behind a not-ready source, then drain in alloc order
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, MUL, 5'(10 + k), 5'd20, 1'b0, 5'd0, 1'b1);
            stepClock();
            checkOutput("fill in_ready", 32'(in_ready), (k == 3) ? 32'd0 : 32'd1);
        end
        in_valid = 1'b0;
        commit_ready[20] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            stepClock();
            checkOutput("drain enable",   32'(enable),   32'd1);
            checkOutput("drain rd",       32'(rd),       32'(10 + k));
            checkOutput("drain in_ready", 32'(in_ready), 32'd1);
        end
        commit_ready = '0;
        stepClock();

        // Scenario: picked op squashed in the same clock; next op issues the clock after
        applyStimulus(1'b1, MUL, 5'd8, 5'd21, 1'b0, 5'd0, 1'b1);
        stepClock();
        applyStimulus(1'b1, MUL, 5'd9, 5'd21, 1'b0, 5'd0, 1'b1);
        stepClock();
        in_valid = 1'b0;
        commit_ready[21]  = 1'b1;
        commit_kill_0[8]  = 1'b1;
        stepClock();
        checkOutput("kill suppress", 32'(enable), 32'd0);
        commit_kill_0 = '0;
        stepClock();
        checkOutput("kill next enable", 32'(enable), 32'd1);
        checkOutput("kill next rd",     32'(rd),     32'd9);
        stepClock();
        checkOutput("kill no rd8", 32'(enable), 32'd0);
        commit_ready = '0;

        // Scenario: reset wipes a queue whose ops become ready in the same clock
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, MUL, 5'(1 + k), 5'd22, 1'b0, 5'd0, 1'b1);
            stepClock();
        end
        in_valid = 1'b0;
        reset = 1'b1;
        commit_ready[22] = 1'b1;
        stepClock();
        checkOutput("midreset enable",   32'(enable),   32'd0);
        checkOutput("midreset in_ready", 32'(in_ready), 32'd1);
        checkOutput("midreset rd",       32'(rd),       32'd0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            stepClock();
            checkOutput("midreset no issue", 32'(enable), 32'd0);
        end
        commit_ready = '0;

        // Randomized traffic: sparse wakeups first to build occupancy, then dense
        for (int c = 0; c < 3000; c++) begin
            reset       = ($urandom_range(0, 199) == 0);
            in_valid    = 1'($urandom_range(0, 1));
            in_control  = 7'($urandom());
            in_rd       = 5'($urandom_range(0, 7));
            in_makes_rd = 1'($urandom_range(0, 1));
            in_hart     = 1'($urandom_range(0, 1));
            in_rs1      = 5'($urandom_range(0, 31));
            in_rs1_arch = 1'($urandom_range(0, 1));
            in_rs2      = 5'($urandom_range(0, 31));
            in_rs2_arch = 1'($urandom_range(0, 1));
            commit_ready  = (c < 1500) ? ($urandom() & $urandom()) : ($urandom() | $urandom());
            commit_kill_0 = ($urandom_range(0, 7) == 0) ? (32'd1 << $urandom_range(0, 7)) : 32'd0;
            divide_busy   = ($urandom_range(0, 9) < 3);
            stepClock();
        end

        reset         = 1'b0;
        in_valid      = 1'b0;
        commit_kill_0 = '0;
        repeat (5) stepClock();
        $display("== %0d vectors applied, %0d miscompares ==", nCompares, nMiscompares);
        $finish;
    end

endmodule
